// File: rtl/assert_event_logger.sv
// Assertion event logger: pass/fail statistics, a free-running cycle stamp, and a
// small FIFO of failure timestamps with overflow tracking.
module assert_event_logger #(
    parameter int CNT_W = 16,
    parameter int TS_W  = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_valid,
    input  logic             chk_pass,
    input  logic             clr,
    input  logic             log_pop,
    output logic             log_valid,
    output logic [TS_W-1:0]  log_ts,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_sticky,
    output logic [TS_W-1:0]  first_fail_ts,
    output logic             overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);

    logic [TS_W-1:0]  ts_reg;
    logic [TS_W-1:0]  mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [CNT_W-1:0] pass_cnt_reg;
    logic [CNT_W-1:0] fail_cnt_reg;
    logic             err_sticky_reg;
    logic [TS_W-1:0]  first_fail_ts_reg;
    logic             overflow_reg;

    logic pass_event;
    logic fail_event;
    logic pop_ok;
    logic fifo_full;
    logic push_ok;

    always_comb begin
        pass_event = chk_valid && chk_pass;
        fail_event = chk_valid && !chk_pass;
        pop_ok     = log_pop && (count_reg != '0);
        fifo_full  = (count_reg == DEPTH_C);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok    = fail_event && (!fifo_full || pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_reg            <= '0;
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
            pass_cnt_reg      <= '0;
            fail_cnt_reg      <= '0;
            err_sticky_reg    <= 1'b0;
            first_fail_ts_reg <= '0;
            overflow_reg      <= 1'b0;
        end else begin
            ts_reg <= ts_reg + TS_W'(1);
            if (clr) begin
                wr_ptr_reg        <= '0;
                rd_ptr_reg        <= '0;
                count_reg         <= '0;
                pass_cnt_reg      <= '0;
                fail_cnt_reg      <= '0;
                err_sticky_reg    <= 1'b0;
                first_fail_ts_reg <= '0;
                overflow_reg      <= 1'b0;
            end else begin
                if (pass_event && pass_cnt_reg != CNT_MAX)
                    pass_cnt_reg <= pass_cnt_reg + CNT_W'(1);
                if (fail_event) begin
                    if (fail_cnt_reg != CNT_MAX)
                        fail_cnt_reg <= fail_cnt_reg + CNT_W'(1);
                    if (!err_sticky_reg)
                        first_fail_ts_reg <= ts_reg;
                    err_sticky_reg <= 1'b1;
                    if (!push_ok)
                        overflow_reg <= 1'b1;
                end
                if (push_ok)
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop_ok)
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                case ({push_ok, pop_ok})
                    2'b10:   count_reg <= count_reg + (AW+1)'(1);
                    2'b01:   count_reg <= count_reg - (AW+1)'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    // Storage carries no reset; validity is tracked solely by count_reg.
    always_ff @(posedge clk) begin
        if (!rst && !clr && push_ok)
            mem[wr_ptr_reg] <= ts_reg;
    end

    always_comb begin
        log_valid     = (count_reg != '0);
        log_ts        = log_valid ? mem[rd_ptr_reg] : '0;
        pass_cnt      = pass_cnt_reg;
        fail_cnt      = fail_cnt_reg;
        err_sticky    = err_sticky_reg;
        first_fail_ts = first_fail_ts_reg;
        overflow      = overflow_reg;
    end
endmodule

// File: tb/tb_assert_event_logger.sv
// Directed scenarios followed by random traffic, all compared every cycle against
// a queue-based reference model of the logger.
module tb_assert_event_logger;
    localparam int CNT_W = 4;
    localparam int TS_W  = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             chk_valid = 1'b0;
    logic             chk_pass = 1'b0;
    logic             clr = 1'b0;
    logic             log_pop = 1'b0;
    logic             log_valid;
    logic [TS_W-1:0]  log_ts;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             err_sticky;
    logic [TS_W-1:0]  first_fail_ts;
    logic             overflow;

    assert_event_logger #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .chk_valid(chk_valid), .chk_pass(chk_pass),
        .clr(clr), .log_pop(log_pop), .log_valid(log_valid), .log_ts(log_ts),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_sticky(err_sticky),
        .first_fail_ts(first_fail_ts), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model
    int m_ts, m_pass, m_fail, m_ffts;
    bit m_err, m_ovf;
    int m_q[$];
    int total = 0;
    int passed = 0;
    int cnt_max = (1 << CNT_W) - 1;
    int ts_mod  = 1 << TS_W;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_pass = 0; m_fail = 0; m_ffts = 0; m_err = 0; m_ovf = 0;
        m_q.delete();
    endtask

    task automatic model_cycle(input bit r, input bit v, input bit p, input bit c, input bit pp);
        int ev_ts;
        ev_ts = m_ts;
        if (r) begin
            m_ts = 0;
            model_clear();
        end else begin
            m_ts = (m_ts + 1) % ts_mod;
            if (c) model_clear();
            else begin
                if (pp && m_q.size() > 0) void'(m_q.pop_front());
                if (v && p) m_pass = (m_pass < cnt_max) ? m_pass + 1 : cnt_max;
                if (v && !p) begin
                    m_fail = (m_fail < cnt_max) ? m_fail + 1 : cnt_max;
                    if (!m_err) m_ffts = ev_ts;
                    m_err = 1;
                    if (m_q.size() < DEPTH) m_q.push_back(ev_ts);
                    else m_ovf = 1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".log_valid"}, 32'(log_valid), 32'(m_q.size() != 0));
        chk({tag, ".log_ts"}, 32'(log_ts), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        chk({tag, ".pass_cnt"}, 32'(pass_cnt), 32'(m_pass));
        chk({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(m_fail));
        chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_err));
        chk({tag, ".first_fail_ts"}, 32'(first_fail_ts), 32'(m_ffts));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step(input string tag, input bit r, input bit v, input bit p, input bit c, input bit pp);
        rst = r; chk_valid = v; chk_pass = p; clr = c; log_pop = pp;
        @(posedge clk);
        model_cycle(r, v, p, c, pp);
        #1;
        check_all(tag);
        $display("step %-6s rst=%0b v=%0b p=%0b clr=%0b pop=%0b -> ts_model=%0d lv=%0b lts=%0d pc=%0d fc=%0d ovf=%0b",
                 tag, r, v, p, c, pp, m_ts, log_valid, log_ts, pass_cnt, fail_cnt, overflow);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int n_ts;
        m_ts = 0;
        model_clear();

        // Pass at ts 0,1, fail at ts 2
        step("rst", 1, 0, 0, 0, 0);
        step("rst", 1, 0, 0, 0, 0);
        step("r34", 0, 1, 1, 0, 0);
        step("r34", 0, 1, 1, 0, 0);
        step("r34", 0, 1, 0, 0, 0);
        chk("r34_pass_cnt", 32'(pass_cnt), 32'd2);
        chk("r34_fail_cnt", 32'(fail_cnt), 32'd1);
        chk("r34_first_fail", 32'(first_fail_ts), 32'd2);
        chk("r34_log_ts", 32'(log_ts), 32'd2);

        // Fails at ts 3,5,7,9,11 into a 4-deep log
        step("rst", 1, 0, 0, 0, 0);
        idle("r35", 3);
        for (int k = 0; k < 5; k++) begin
            step("r35", 0, 1, 0, 0, 0);
            if (k < 4) idle("r35", 1);
        end
        chk("r35_fail_cnt", 32'(fail_cnt), 32'd5);
        chk("r35_overflow", 32'(overflow), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("r35_pop_ts", 32'(log_ts), 32'(3 + 2 * k));
            step("r35p", 0, 0, 0, 0, 1);
        end
        chk("r35_empty", 32'(log_valid), 32'd0);
        step("r35p", 0, 0, 0, 0, 1);

        // Full FIFO with simultaneous fail and pop
        step("clr", 0, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) step("r36", 0, 1, 0, 0, 0);
        step("r36", 0, 1, 0, 0, 1);
        chk("r36_overflow", 32'(overflow), 32'd0);
        chk("r36_depth", 32'(m_q.size()), 32'd4);

        // Pass counter saturation
        step("clr", 0, 0, 0, 1, 0);
        for (int k = 0; k < 20; k++) step("r37", 0, 1, 1, 0, 0);
        chk("r37_sat", 32'(pass_cnt), 32'd15);

        // clr beats a same-cycle fail and pop
        step("r38", 0, 1, 0, 1, 1);
        chk("r38_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("r38_log_valid", 32'(log_valid), 32'd0);
        idle("r38", 2);
        n_ts = m_ts;
        step("r38", 0, 1, 0, 0, 0);
        chk("r38_first_fail", 32'(first_fail_ts), 32'(n_ts));

        // rst with 2 entries logged; ts restarts at 0
        step("r39", 0, 1, 0, 0, 0);
        step("rst", 1, 0, 0, 0, 0);
        chk("r39_log_valid", 32'(log_valid), 32'd0);
        chk("r39_fail_cnt", 32'(fail_cnt), 32'd0);
        step("r39", 0, 1, 0, 0, 0);
        chk("r39_ts_restart", 32'(first_fail_ts), 32'd0);

        // Random traffic, long enough to wrap the 8-bit timestamp
        for (int i = 0; i < 600; i++) begin
            bit r, c, v, p, pp;
            r  = ($urandom_range(0, 199) == 0);
            c  = ($urandom_range(0, 59) == 0);
            v  = $urandom_range(0, 1);
            p  = $urandom_range(0, 2) == 0;
            pp = ($urandom_range(0, 99) < ((i % 100) < 50 ? 15 : 70));
            step("rand", r, v, p, c, pp);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/assert_event_logger.md
ASSERT_EVENT_LOGGER -- requirements
Module: assert_event_logger

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of pass/fail counters.
REQ-002 SHALL have parameter TS_W, default 32, width of cycle timestamp.
REQ-003 SHALL have parameter DEPTH, default 4, fail-log FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port chk_valid  input  1  a check was evaluated this cycle.
REQ-007 SHALL have port chk_pass  input  1  check result (1 = pass, 0 = fail); don't-care when chk_valid=0.
REQ-008 SHALL have port clr  input  1  synchronous clear of statistics and log.
REQ-009 SHALL have port log_pop  input  1  consumer accepts log_ts head entry.
REQ-010 SHALL have port log_valid  output  1  fail-log FIFO non-empty.
REQ-011 SHALL have port log_ts  output  TS_W  timestamp of oldest logged failure (show-ahead).
REQ-012 SHALL have port pass_cnt  output  CNT_W  saturating count of passing checks.
REQ-013 SHALL have port fail_cnt  output  CNT_W  saturating count of failing checks.
REQ-014 SHALL have port err_sticky  output  1  at least one failure since reset/clr.
REQ-015 SHALL have port first_fail_ts  output  TS_W  timestamp of first failure since reset/clr.
REQ-016 SHALL have port overflow  output  1  sticky; a failure was dropped because FIFO was full.

Function
REQ-017 SHALL keep free-running cycle counter ts: 0 in first cycle after rst deasserts, +1 per cycle, wraps 2^TS_W-1 -> 0; clr does not affect ts.
REQ-018 SHALL treat an event as chk_valid=1 sampled at posedge; event timestamp = ts value in that cycle.
REQ-019 SHALL on pass event increment pass_cnt, holding at 2^CNT_W-1 (no wrap).
REQ-020 SHALL on fail event increment fail_cnt, holding at 2^CNT_W-1 (no wrap).
REQ-021 SHALL make counter/sticky/first_fail_ts updates visible the cycle after the event (1-cycle latency).
REQ-022 SHALL on fail event set err_sticky; if err_sticky was 0, load first_fail_ts with event timestamp; later fails leave first_fail_ts unchanged.
REQ-023 SHALL on fail event push event timestamp into FIFO; log_valid rises the cycle after push into empty FIFO.
REQ-024 SHALL pop head when log_pop=1 and log_valid=1; log_pop with log_valid=0 ignored, no state change.
REQ-025 SHALL, when FIFO full and fail event without pop, drop the timestamp, set overflow, still increment fail_cnt.
REQ-026 SHALL, when FIFO full and fail event with pop same cycle, perform both; no overflow; occupancy stays DEPTH.
REQ-027 SHALL, when FIFO empty, not allow same-cycle push bypass: log_valid stays 0 that cycle.
REQ-028 SHALL present entries in strict push order; pointers wrap modulo DEPTH.
REQ-029 SHALL give clr priority over a same-cycle event and pop: event and pop discarded, not counted.
REQ-030 SHALL keep log_ts = 0 when log_valid=0.

Reset
REQ-031 SHALL on rst: ts=0, pass_cnt=0, fail_cnt=0, err_sticky=0, first_fail_ts=0, overflow=0, FIFO empty (log_valid=0, log_ts=0).
REQ-032 SHALL on clr: same as REQ-031 except ts continues counting.
REQ-033 SHALL let rst override clr and all events; rst mid-operation discards FIFO contents.

Verification
REQ-034 Bench SHALL cover: rst then pass events at ts 0,1 and fail at ts 2 -> pass_cnt=2, fail_cnt=1, err_sticky=1, first_fail_ts=2, log_valid=1, log_ts=2.
REQ-035 Bench SHALL cover: fails at ts 3,5,7,9,11 with no pop (DEPTH=4) -> fail_cnt=5, overflow=1, pops yield 3,5,7,9 then log_valid=0.
REQ-036 Bench SHALL cover: FIFO full, fail with log_pop same cycle -> oldest popped, new stamp appended, overflow stays 0, occupancy 4.
REQ-037 Bench SHALL cover: CNT_W=4, 20 pass events -> pass_cnt saturates at 15.
REQ-038 Bench SHALL cover: clr asserted with a fail event same cycle -> all stats 0, log empty, ts unaffected; next fail at ts=N sets first_fail_ts=N.
REQ-039 Bench SHALL cover: rst asserted with 2 entries logged -> next cycle log_valid=0, counters 0, ts restarts at 0.
